sar_adc_control: RTL and testbench

Successive-approximation ADC controller, the receive-side counterpart of the R2R DAC path. It drives the 8-bit code into the on-chip R2R ladder and reads back an external analog comparator (analog input versus ladder output). It performs a binary search, one bit per settle window, and presents the converted code with a one-cycle valid strobe. It sits beside `r2r_dac_control` in the analog tile top and time-shares the ladder with it through a top-level mux.

---
 rtl/sar_adc_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/sar_adc_control.sv | 109 ++++++++++
 tb/tb_sar_adc_control.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sar_adc_pkg.sv
// Shared types and constants for the successive-approximation ADC controller.
package sar_adc_pkg;

  typedef enum logic {
    IDLE,
    TRIAL
  } sar_state_t;

  localparam int DEFAULT_WIDTH         = 8;
  localparam int DEFAULT_SETTLE_CYCLES = 4;

  // The comparator needs a ladder settle cycle plus two sync flops before a decision.
  localparam int SETTLE_CYCLES_MIN = 3;
  localparam int SETTLE_CYCLES_MAX = 255;

  function automatic bit settle_cycles_legal(input int n);
    return (n >= SETTLE_CYCLES_MIN) && (n <= SETTLE_CYCLES_MAX);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, async active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sar_adc_control.sv
// SAR ADC controller: binary search on the R2R ladder against an external
// comparator, one bit per settle window, with a one-cycle valid strobe.
module sar_adc_control
  import sar_adc_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_out,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  localparam int               IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(WIDTH - 1);
  localparam logic [7:0]       CNT_RELOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MSB_CODE   = {1'b1, {(WIDTH - 1){1'b0}}};

  generate
    if (!settle_cycles_legal(SETTLE_CYCLES)) begin : g_bad_settle
      $error("sar_adc_control: SETTLE_CYCLES out of range 3..255");
    end
  endgenerate

  sar_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [7:0]       cnt;
  logic             cmp_s;
  logic [WIDTH-1:0] decided_code;
  logic [WIDTH-1:0] next_trial_code;

  sync_2ff u_cmp_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (cmp_in),
    .q     (cmp_s)
  );

  // During a trial dac_out is the working code; bits below idx are still 0.
  always_comb begin
    decided_code                  = dac_out;
    decided_code[idx]             = cmp_s;
    idx_next                      = idx - IDX_W'(1);
    next_trial_code               = decided_code;
    next_trial_code[idx_next]     = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      dac_out <= '0;
      result  <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      idx     <= '0;
      cnt     <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            state   <= TRIAL;
            busy    <= 1'b1;
            dac_out <= MSB_CODE;
            idx     <= IDX_TOP;
            cnt     <= CNT_RELOAD;
          end
        end

        TRIAL: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (idx != '0) begin
            dac_out <= next_trial_code;
            idx     <= idx_next;
            cnt     <= CNT_RELOAD;
          end else begin
            result <= decided_code;
            valid  <= 1'b1;
            if (continuous) begin
              dac_out <= MSB_CODE;
              idx     <= IDX_TOP;
              cnt     <= CNT_RELOAD;
            end else begin
              // Ladder replays the fresh sample while idle.
              state   <= IDLE;
              busy    <= 1'b0;
              dac_out <= decided_code;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_control.sv
// Directed self-checking bench for sar_adc_control with ideal and slow comparator models.
module tb_sar_adc_control;

  logic       clk;
  logic       n_rst;
  logic       start;
  logic       continuous;
  logic [7:0] vin_a;
  logic       cmp_a;
  logic [7:0] dac_a;
  logic       busy_a;
  logic       valid_a;
  logic [7:0] result_a;

  logic       start_b;
  logic       continuous_b;
  logic [7:0] vin_b;
  logic       cmp_b;
  logic [7:0] dac_b;
  logic       busy_b;
  logic       valid_b;
  logic [7:0] result_b;

  int check_count;
  int error_count;
  int valid_seen_a;
  int valid_seen_b;
  int busy_drops;

  logic [7:0] a5_trace [8];

  // Ideal comparator for the default instance.
  assign cmp_a = (vin_a >= dac_a);

  // Slow comparator: output settles 7 time units (most of a clock) after the ladder moves.
  assign #7 cmp_b = (vin_b >= dac_b);

  sar_adc_control #(
    .WIDTH         (8),
    .SETTLE_CYCLES (4)
  ) dut_a (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .continuous (continuous),
    .cmp_in     (cmp_a),
    .dac_out    (dac_a),
    .busy       (busy_a),
    .valid      (valid_a),
    .result     (result_a)
  );

  sar_adc_control #(
    .WIDTH         (8),
    .SETTLE_CYCLES (3)
  ) dut_b (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start_b),
    .continuous (continuous_b),
    .cmp_in     (cmp_b),
    .dac_out    (dac_b),
    .busy       (busy_b),
    .valid      (valid_b),
    .result     (result_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (valid_a) valid_seen_a++;
    if (valid_b) valid_seen_b++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Single-shot conversion on the default instance; start sampled in cycle 0.
  task automatic applyStimulus(input logic [7:0] v, input bit check_trace);
    vin_a        = v;
    valid_seen_a = 0;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    checkOutput($sformatf("busy_c1_%02h", v), {31'd0, busy_a}, 32'd1);
    for (int bit_n = 0; bit_n < 8; bit_n++) begin
      if (check_trace)
        checkOutput($sformatf("trace_%0d", bit_n), {24'd0, dac_a}, {24'd0, a5_trace[bit_n]});
      for (int c = 0; c < 4; c++) tick();
    end
    checkOutput($sformatf("valid_c33_%02h", v), {31'd0, valid_a}, 32'd1);
    checkOutput($sformatf("result_%02h", v), {24'd0, result_a}, {24'd0, v});
    checkOutput($sformatf("busy_c33_%02h", v), {31'd0, busy_a}, 32'd0);
    checkOutput($sformatf("dac_c33_%02h", v), {24'd0, dac_a}, {24'd0, v});
    tick();
    checkOutput($sformatf("valid_c34_%02h", v), {31'd0, valid_a}, 32'd0);
    checkOutput($sformatf("dac_idle_%02h", v), {24'd0, dac_a}, {24'd0, v});
    checkOutput($sformatf("valid_count_%02h", v), valid_seen_a, 32'd1);
  endtask

  initial begin
    a5_trace     = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    check_count  = 0;
    error_count  = 0;
    valid_seen_a = 0;
    valid_seen_b = 0;
    busy_drops   = 0;
    start        = 1'b0;
    continuous   = 1'b0;
    start_b      = 1'b0;
    continuous_b = 1'b0;
    vin_a        = 8'h00;
    vin_b        = 8'h00;
    n_rst        = 1'b1;
    #2;
    n_rst        = 1'b0;
    tick();
    tick();
    checkOutput("rst_dac", {24'd0, dac_a}, 32'd0);
    checkOutput("rst_result", {24'd0, result_a}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("rst_valid", {31'd0, valid_a}, 32'd0);
    n_rst = 1'b1;
    tick();

    $display("[TB] ideal comparator, vin=0xA5");
    applyStimulus(8'hA5, 1'b1);

    $display("[TB] reset at cycle 10 of a conversion");
    vin_a = 8'h3C;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    checkOutput("pre_rst_busy", {31'd0, busy_a}, 32'd1);
    n_rst = 1'b0;
    #1;
    checkOutput("mid_rst_dac", {24'd0, dac_a}, 32'd0);
    checkOutput("mid_rst_result", {24'd0, result_a}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("mid_rst_valid", {31'd0, valid_a}, 32'd0);
    tick();
    n_rst = 1'b1;
    tick();
    applyStimulus(8'h3C, 1'b0);

    $display("[TB] extremes");
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'hFF, 1'b0);
    applyStimulus(8'h80, 1'b0);

    $display("[TB] start pulses during conversion");
    vin_a        = 8'h6B;
    valid_seen_a = 0;
    start        = 1'b1;
    tick();
    for (int c = 1; c <= 32; c++) begin
      start = (c == 5 || c == 20);
      tick();
    end
    start = 1'b0;
    checkOutput("pulse_valid_c33", {31'd0, valid_a}, 32'd1);
    checkOutput("pulse_result", {24'd0, result_a}, 32'h6B);
    tick();
    tick();
    checkOutput("pulse_not_queued", {31'd0, busy_a}, 32'd0);
    checkOutput("pulse_valid_count", valid_seen_a, 32'd1);

    $display("[TB] continuous mode");
    vin_a        = 8'h10;
    continuous   = 1'b1;
    valid_seen_a = 0;
    busy_drops   = 0;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    for (int c = 2; c <= 33; c++) begin
      tick();
      if (!busy_a) busy_drops++;
    end
    checkOutput("cont_valid_c33", {31'd0, valid_a}, 32'd1);
    checkOutput("cont_result1", {24'd0, result_a}, 32'h10);
    checkOutput("cont_dac_c33", {24'd0, dac_a}, 32'h80);
    vin_a = 8'hF0;
    tick();
    if (!busy_a) busy_drops++;
    continuous = 1'b0;
    for (int c = 35; c <= 64; c++) begin
      tick();
      if (!busy_a) busy_drops++;
    end
    checkOutput("cont_busy_drops", busy_drops, 32'd0);
    checkOutput("cont_valid_c64", {31'd0, valid_a}, 32'd0);
    tick();
    checkOutput("cont_valid_c65", {31'd0, valid_a}, 32'd1);
    checkOutput("cont_result2", {24'd0, result_a}, 32'hF0);
    checkOutput("cont_busy_end", {31'd0, busy_a}, 32'd0);
    checkOutput("cont_valid_count", valid_seen_a, 32'd2);

    $display("[TB] SETTLE_CYCLES=3 with slow comparator, 256 random codes");
    for (int n = 0; n < 256; n++) begin
      vin_b   = 8'($urandom_range(0, 255));
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int w = 0; w < 40 && !valid_b; w++) tick();
      checkOutput($sformatf("slow_valid_%0d", n), {31'd0, valid_b}, 32'd1);
      checkOutput($sformatf("slow_result_%0d", n), {24'd0, result_b}, {24'd0, vin_b});
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
